// File: rtl/image_stream_loader.sv
`timescale 1ns/1ps
// Writes an inbound 8-bit pixel stream into data memory from a fixed base
// address, tracking byte count, a 16-bit running checksum and completion.
module image_stream_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned IMG_BYTES = 160000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_count,
    output logic [15:0]       checksum
);

    localparam int unsigned       CSUM_W   = 16;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] IMG_CNT  = ADDR_W'(IMG_BYTES);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(IMG_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                mem_we_q, mem_we_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]   byte_count_q, byte_count_d;
    logic [CSUM_W-1:0]   checksum_q, checksum_d;
    logic                accept_c;

    // A byte raced by abort is dropped; the count guard keeps byte_count saturated.
    assign accept_c = (state_q == LOAD) && in_ready_q && in_valid && !abort
                      && (byte_count_q != IMG_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
            mem_addr_q   <= BASE;
            mem_wdata_q  <= '0;
            byte_count_q <= '0;
            checksum_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            mem_we_q     <= mem_we_d;
            done_q       <= done_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        busy_d       = busy_q;
        mem_we_d     = 1'b0;
        done_d       = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;

        if (accept_c) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = BASE + byte_count_q;
            mem_wdata_d  = in_data;
            byte_count_d = byte_count_q + ADDR_W'(1);
            checksum_d   = checksum_q + CSUM_W'(in_data);
        end

        if (abort) begin
            state_d    = IDLE;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_d      = LOAD;
                        in_ready_d   = 1'b1;
                        busy_d       = 1'b1;
                        byte_count_d = '0;
                        checksum_d   = '0;
                    end
                end
                LOAD: begin
                    // done rides with the final write so both appear on the same cycle
                    if (accept_c && (byte_count_q == LAST_CNT)) begin
                        state_d    = DONE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d    = IDLE;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign mem_we     = mem_we_q;
    assign done       = done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_image_stream_loader.sv
`timescale 1ns/1ps
// Scoreboarded bench for image_stream_loader with a 16-byte image at base 0x100.
module tb_image_stream_loader;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 18;
    localparam int unsigned BASE   = 32'h100;
    localparam int unsigned IMG    = 16;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic              abort;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] byte_count;
    logic [15:0]       checksum;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wr_cnt   = 0;
    int          done_cnt = 0;
    bit          mon_en   = 1'b0;
    exp_t        exp_q[$];
    exp_t        e;
    int          m_st  = M_IDLE;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;
    int          w0, d0;

    image_stream_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .IMG_BYTES(IMG)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .byte_count(byte_count), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every write must match the head of the scoreboard, including the cycle it lands on.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) done_cnt++;
            if (mem_we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check_eq("wr_data", 32'(mem_wdata), 32'(e.data));
                    check_eq("wr_done", 32'(done), 32'(e.last));
                    check_eq("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check_eq("done_without_write", 32'(done), 32'd0);
            end
        end
    end

    // One clock of stimulus; expectations come from a behavioural model of the load FSM.
    task automatic cycle(input logic v, input logic [7:0] d, input logic ab, input logic ls);
        in_valid = v; in_data = d; abort = ab; load_start = ls;
        @(negedge clk);
        check_eq("in_ready", 32'(in_ready), 32'(m_st == M_LOAD));
        check_eq("busy", 32'(busy), 32'(m_st == M_LOAD));
        check_eq("byte_count", 32'(byte_count), 32'(m_cnt));
        check_eq("checksum", 32'(checksum), 32'(m_sum));
        if (ab) begin
            m_st = M_IDLE;
        end else if (m_st == M_IDLE) begin
            if (ls) begin m_st = M_LOAD; m_cnt = 0; m_sum = '0; end
        end else if (m_st == M_LOAD) begin
            if (v) begin
                exp_q.push_back('{addr: ADDR_W'(BASE + 32'(m_cnt)), data: d,
                                  last: (m_cnt == IMG - 1), cyc: cyc + 1});
                m_cnt++;
                m_sum = m_sum + 16'(d);
                if (m_cnt == IMG) m_st = M_DONE;
            end
        end else begin
            m_st = M_IDLE;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; load_start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), BASE);
        check_eq("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst_byte_count", 32'(byte_count), 32'd0);
        check_eq("rst_checksum", 32'(checksum), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // clean back-to-back load
        w0 = wr_cnt; d0 = done_cnt;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("clean_count", 32'(byte_count), 32'd16);
        check_eq("clean_sum", 32'(checksum), 32'h0078);
        check_eq("clean_writes", 32'(wr_cnt - w0), 32'd16);
        check_eq("clean_done", 32'(done_cnt - d0), 32'd1);
        check_eq("clean_pending", 32'(exp_q.size()), 32'd0);

        // bytes in IDLE without load_start are ignored
        repeat (2) cycle(1'b1, 8'hAA, 1'b0, 1'b0);

        // gapped stream
        w0 = wr_cnt; d0 = done_cnt;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) cycle(logic'(i % 2 == 0), 8'hFF, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("gap_sum", 32'(checksum), 32'h0FF0);
        check_eq("gap_writes", 32'(wr_cnt - w0), 32'd16);
        check_eq("gap_done", 32'(done_cnt - d0), 32'd1);

        // overrun: 20 bytes offered, only 16 written; load_start in DONE ignored
        w0 = wr_cnt; d0 = done_cnt;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h40, 1'b0, 1'b1);
        for (int i = 17; i < 20; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("ovr_writes", 32'(wr_cnt - w0), 32'd16);
        check_eq("ovr_done", 32'(done_cnt - d0), 32'd1);
        check_eq("ovr_count", 32'(byte_count), 32'd16);

        // abort on the 8th byte
        w0 = wr_cnt; d0 = done_cnt;
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h57, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("abort_count", 32'(byte_count), 32'd7);
        check_eq("abort_sum", 32'(checksum), 32'h0245);
        check_eq("abort_writes", 32'(wr_cnt - w0), 32'd7);
        check_eq("abort_done", 32'(done_cnt - d0), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b1, 8'hC1, 1'b0, 1'b0);
        cycle(1'b1, 8'hC2, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // abort beats load_start in IDLE
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        check_eq("abort_ls_busy", 32'(busy), 32'd0);

        // asynchronous reset between edges mid-load
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_in_ready", 32'(in_ready), 32'd0);
        check_eq("arst_mem_we", 32'(mem_we), 32'd0);
        check_eq("arst_mem_addr", 32'(mem_addr), BASE);
        check_eq("arst_count", 32'(byte_count), 32'd0);
        exp_q.delete();
        m_st = M_IDLE; m_cnt = 0; m_sum = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        w0 = wr_cnt;
        repeat (3) cycle(1'b1, 8'h11, 1'b0, 1'b0);
        check_eq("arst_idle_writes", 32'(wr_cnt - w0), 32'd0);
        check_eq("final_pending", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
